// File: rtl/sha512_digest_reader.sv
// Copies NUM_WORDS digest words from the SHA-512 core into the result RAM after a finished hash.
// Define SHA512_DIGEST_BSWAP_EN to store each word byte-reversed (little-endian byte order).
module sha512_digest_reader #(
   parameter logic [7:0] DIGEST_BASE = 8'h10,
   parameter int         NUM_WORDS   = 16,
   parameter int         OUT_ADDR_W  = 9
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [OUT_ADDR_W-1:0] out_base,
   output logic [7:0]            do_address,
   input  logic [31:0]           data_in,
   input  logic                  error_in,
   output logic                  wr_en,
   output logic [OUT_ADDR_W-1:0] wr_addr,
   output logic [31:0]           wr_data,
   input  logic                  wr_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [1:0]            state_dbg
);

   generate
      if (NUM_WORDS < 1 || NUM_WORDS > 16) begin : g_bad_num_words
         $error("sha512_digest_reader: NUM_WORDS must be within 1..16");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   localparam logic [3:0] LAST_IDX = 4'(NUM_WORDS - 1);

   state_t                state_q, state_d;
   logic [3:0]            idx_q, idx_d;
   logic [OUT_ADDR_W-1:0] base_q, base_d;
   logic [7:0]            do_address_q, do_address_d;
   logic                  wr_en_q, wr_en_d;
   logic [OUT_ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]           wr_data_q, wr_data_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [31:0]           rd_word;

`ifdef SHA512_DIGEST_BSWAP_EN
   assign rd_word = {data_in[7:0], data_in[15:8], data_in[23:16], data_in[31:24]};
`else
   assign rd_word = data_in;
`endif

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      base_d       = base_q;
      do_address_d = do_address_q;
      wr_en_d      = wr_en_q;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      err_d        = err_q;
      case (state_q)
         IDLE: begin
            do_address_d = DIGEST_BASE;
            if (start) begin
               state_d = READ;
               base_d  = out_base;
               idx_d   = 4'd0;
               err_d   = 1'b0;
               busy_d  = 1'b1;
            end
         end
         READ: begin
            // data_in is a combinational read of the address registered on entry to READ
            wr_data_d = rd_word;
            if (error_in) err_d = 1'b1;
            wr_en_d   = 1'b1;
            wr_addr_d = base_q + OUT_ADDR_W'(idx_q);
            state_d   = WRITE;
         end
         WRITE: begin
            if (wr_ready) begin
               wr_en_d = 1'b0;
               idx_d   = idx_q + 4'd1;
               if (idx_q == LAST_IDX) begin
                  state_d      = DONE;
                  done_d       = 1'b1;
                  busy_d       = 1'b0;
                  do_address_d = DIGEST_BASE;
               end else begin
                  state_d      = READ;
                  do_address_d = DIGEST_BASE + {4'b0000, idx_q + 4'd1};
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         idx_q        <= 4'd0;
         base_q       <= '0;
         do_address_q <= DIGEST_BASE;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= 32'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         base_q       <= base_d;
         do_address_q <= do_address_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign do_address = do_address_q;
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_sha512_digest_reader.sv
// Bench for sha512_digest_reader: a 16-word and an 8-word instance share stimulus and are
// checked against a cycle-walk model of the copy built from the core memory image.
module tb_sha512_digest_reader;

   localparam logic [7:0] DB = 8'h10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, error_in, wr_ready;
   logic [8:0]  out_base;
   logic [31:0] core_mem [0:255];

   logic [7:0]  do_address [2];
   logic [31:0] data_in    [2];
   logic        wr_en      [2];
   logic [8:0]  wr_addr    [2];
   logic [31:0] wr_data    [2];
   logic        busy       [2];
   logic        done       [2];
   logic        err        [2];
   logic [1:0]  state_dbg  [2];

   assign data_in[0] = core_mem[do_address[0]];
   assign data_in[1] = core_mem[do_address[1]];

   sha512_digest_reader #(.DIGEST_BASE(DB), .NUM_WORDS(16), .OUT_ADDR_W(9)) u_dut_a (
      .clk(clk), .reset(reset), .start(start), .out_base(out_base),
      .do_address(do_address[0]), .data_in(data_in[0]), .error_in(error_in),
      .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .wr_ready(wr_ready),
      .busy(busy[0]), .done(done[0]), .err(err[0]), .state_dbg(state_dbg[0]));

   sha512_digest_reader #(.DIGEST_BASE(DB), .NUM_WORDS(8), .OUT_ADDR_W(9)) u_dut_b (
      .clk(clk), .reset(reset), .start(start), .out_base(out_base),
      .do_address(do_address[1]), .data_in(data_in[1]), .error_in(error_in),
      .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .wr_ready(wr_ready),
      .busy(busy[1]), .done(done[1]), .err(err[1]), .state_dbg(state_dbg[1]));

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] xf(input logic [31:0] d);
`ifdef SHA512_DIGEST_BSWAP_EN
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
      return d;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: records completed writes and done pulses, and checks outputs hold during a stall.
   logic [40:0] obs0_q[$];
   logic [40:0] obs1_q[$];
   int          done_cnt [2];
   int          done_cyc [2];
   logic        stall_prev [2];
   logic [49:0] snap [2];

   initial begin
      for (int k = 0; k < 2; k++) begin
         stall_prev[k] = 1'b0;
         done_cnt[k]   = 0;
         done_cyc[k]   = 0;
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (stall_prev[k] && !reset)
            check(k == 0 ? "hold_a" : "hold_b",
                  {14'd0, wr_en[k], wr_addr[k], wr_data[k], do_address[k]}, {14'd0, snap[k]});
         stall_prev[k] = wr_en[k] && !wr_ready && !reset;
         snap[k]       = {wr_en[k], wr_addr[k], wr_data[k], do_address[k]};
         if (wr_en[k] && wr_ready) begin
            if (k == 0) obs0_q.push_back({wr_addr[0], wr_data[0]});
            else        obs1_q.push_back({wr_addr[1], wr_data[1]});
         end
         if (done[k]) begin
            done_cnt[k]++;
            done_cyc[k] = cyc;
         end
      end
   end

   // Reference model: per-cycle ready pattern and error pattern, walked word by word.
   bit rdy_pat [0:255];
   bit errp    [0:255];
   int rd_off  [0:15];
   int done_off [2];

   task automatic model(input int n, input int k);
      int t;
      t = 1;
      for (int i = 0; i < n; i++) begin
         rd_off[i] = t;
         t++;
         while (t < 255 && !rdy_pat[t]) t++;
         t++;
      end
      done_off[k] = t;
   endtask

   task automatic check_reset_vals(input string tag);
      for (int k = 0; k < 2; k++) begin
         check({tag, "_do_address"}, do_address[k], DB);
         check({tag, "_wr_en"},      wr_en[k],      1'b0);
         check({tag, "_wr_addr"},    wr_addr[k],    9'd0);
         check({tag, "_wr_data"},    wr_data[k],    32'd0);
         check({tag, "_busy"},       busy[k],       1'b0);
         check({tag, "_done"},       done[k],       1'b0);
         check({tag, "_err"},        err[k],        1'b0);
      end
   endtask

   // mode 0: ready always, 1: five-cycle stall on word 3, 2: random ready
   task automatic run_copy(input string tag, input logic [8:0] base, input int mode,
                           input int err_word, input bit rand_err, input bit dup_start);
      int          t0;
      int          n;
      bit          exp_err [2];
      logic [40:0] exp_q[$];
      logic [40:0] got;
      for (int o = 0; o < 256; o++) begin
         rdy_pat[o] = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (mode == 1 && o >= 8 && o <= 12) rdy_pat[o] = 1'b0;
         if (o >= 200) rdy_pat[o] = 1'b1;
         errp[o] = rand_err ? ($urandom_range(0, 5) == 0) : 1'b0;
      end
      model(8, 1);
      model(16, 0);
      if (err_word >= 0) errp[rd_off[err_word]] = 1'b1;
      for (int k = 0; k < 2; k++) begin
         exp_err[k] = 1'b0;
         for (int i = 0; i < (k == 0 ? 16 : 8); i++) exp_err[k] |= errp[rd_off[i]];
      end
      obs0_q.delete();
      obs1_q.delete();
      done_cnt[0] = 0;
      done_cnt[1] = 0;
      t0 = cyc;
      for (int o = 0; o <= done_off[0] + 1; o++) begin
         start    = (o == 0) || (dup_start && o == 5);
         out_base = (o == 0) ? base : 9'($urandom);
         wr_ready = rdy_pat[o];
         error_in = errp[o];
         if (o == 1) begin
            check({tag, "_busy_read"}, {busy[0], busy[1]}, 2'b11);
            check({tag, "_err_cleared"}, {err[0], err[1]}, 2'b00);
            check({tag, "_do_address_w0"}, do_address[0], DB);
         end
         tick();
      end
      start    = 1'b0;
      error_in = 1'b0;
      for (int k = 0; k < 2; k++) begin
         n = (k == 0) ? 16 : 8;
         exp_q.delete();
         for (int i = 0; i < n; i++) exp_q.push_back({9'(base + 9'(i)), xf(core_mem[DB + 8'(i)])});
         check({tag, "_nwrites"}, (k == 0) ? obs0_q.size() : obs1_q.size(), n);
         for (int i = 0; i < n; i++) begin
            if (k == 0) got = (i < obs0_q.size()) ? obs0_q[i] : 'x;
            else        got = (i < obs1_q.size()) ? obs1_q[i] : 'x;
            check($sformatf("%s_write%0d_%0d", tag, k, i), got, exp_q[i]);
         end
         check({tag, "_done_cnt"}, done_cnt[k], 1);
         check({tag, "_done_time"}, done_cyc[k] - t0, done_off[k]);
         check({tag, "_err"}, err[k], exp_err[k]);
         check({tag, "_busy_after"}, busy[k], 1'b0);
         check({tag, "_wr_en_after"}, wr_en[k], 1'b0);
      end
   endtask

   localparam logic [31:0] ABC [0:15] = '{
      32'hddaf35a1, 32'h93617aba, 32'hcc417349, 32'hae204131,
      32'h12e6fa4e, 32'h89a97ea2, 32'h0a9eeee6, 32'h4b55d39a,
      32'h2192992a, 32'h274fc1a8, 32'h36ba3c23, 32'ha3feebbd,
      32'h454d4423, 32'h643ce80e, 32'h2a9ac94f, 32'ha54ca49f};

   initial begin
      int t0;
      logic [31:0] w0;
      for (int a = 0; a < 256; a++) core_mem[a] = $urandom;
      for (int i = 0; i < 16; i++) core_mem[DB + 8'(i)] = ABC[i];
      reset = 1'b1; start = 1'b0; error_in = 1'b0; wr_ready = 1'b1; out_base = 9'd0;
      tick();
      tick();
      check_reset_vals("reset");
      reset = 1'b0;
      tick();

      run_copy("abc", 9'h040, 0, -1, 1'b0, 1'b1);
      w0 = 32'hddaf35a1;
      check("abc_word0", obs0_q.size() > 0 ? obs0_q[0][31:0] : 32'hx, xf(w0));
      w0 = 32'h93617aba;
      check("abc_word1", obs0_q.size() > 1 ? obs0_q[1][31:0] : 32'hx, xf(w0));
      check("abc_last_addr", obs0_q.size() > 15 ? obs0_q[15][40:32] : 9'hx, 9'h04F);
      check("abc_b_last_addr", obs1_q.size() > 7 ? obs1_q[7][40:32] : 9'hx, 9'h047);

      run_copy("stall", 9'h040, 1, -1, 1'b0, 1'b0);
      check("stall_done_delay", done_off[0], 38);
      run_copy("wrap", 9'h1F8, 0, -1, 1'b0, 1'b0);
      run_copy("errw2", 9'($urandom), 0, 2, 1'b0, 1'b0);

      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 16; i++) core_mem[DB + 8'(i)] = $urandom;
         run_copy($sformatf("rand%0d", r), 9'($urandom), 2, -1, 1'b1, r[0]);
      end

      // Reset mid-copy: start at T, reset during T+6.
      t0 = cyc;
      start = 1'b1; out_base = 9'h020; wr_ready = 1'b1;
      tick();
      start = 1'b0;
      while (cyc - t0 < 6) tick();
      reset = 1'b1;
      tick();
      check_reset_vals("midreset");
      reset = 1'b0;
      obs0_q.delete();
      obs1_q.delete();
      done_cnt[0] = 0;
      done_cnt[1] = 0;
      for (int i = 0; i < 40; i++) tick();
      check("midreset_no_done_a", done_cnt[0], 0);
      check("midreset_no_done_b", done_cnt[1], 0);
      check("midreset_no_writes", obs0_q.size() + obs1_q.size(), 0);

      run_copy("recover", 9'h100, 2, 5, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
